// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips one rectangle command to the visible area and
// streams one frame-buffer pixel write per clock in row-major order.
module rect_fill_engine #(
   parameter int unsigned HEIGHT = 96,
   parameter int unsigned WIDTH  = 128
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        cmdValid,
   output logic        cmdReady,
   input  logic [6:0]  cmdX0,
   input  logic [6:0]  cmdY0,
   input  logic [6:0]  cmdX1,
   input  logic [6:0]  cmdY1,
   input  logic [2:0]  cmdColor,
   output logic        write,
   output logic [13:0] writeAddress,
   output logic [2:0]  writeData,
   output logic        busy,
   output logic        done
);

   localparam logic [6:0] YMAX = 7'(HEIGHT - 1);
   localparam logic [6:0] XMAX = 7'(WIDTH - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t     state_q, state_d;
   logic [6:0] x_q, x_d, y_q, y_d;
   logic [6:0] x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
   logic [2:0] color_q, color_d;
   logic       write_q, write_d, busy_q, busy_d, done_q, done_d;

   logic [6:0] x1c, y1c, x_inc, y_inc;
   logic       cmd_empty;

   assign x1c       = (cmdX1 > XMAX) ? XMAX : cmdX1;
   assign y1c       = (cmdY1 > YMAX) ? YMAX : cmdY1;
   assign cmd_empty = (cmdX0 > x1c) || (cmdY0 > y1c);
   assign x_inc     = x_q + 7'd1;
   assign y_inc     = y_q + 7'd1;

   assign cmdReady     = resetN && (state_q == IDLE);
   assign write        = write_q;
   assign writeAddress = {y_q, x_q};
   assign writeData    = color_q;
   assign busy         = busy_q;
   assign done         = done_q;

   // done is registered, so it is raised on the edge that presents the last pixel
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      x0_d    = x0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      color_d = color_q;
      write_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmdValid && cmdReady) begin
               if (cmd_empty) begin
                  done_d = 1'b1;
               end else begin
                  state_d = FILL;
                  write_d = 1'b1;
                  busy_d  = 1'b1;
                  x_d     = cmdX0;
                  y_d     = cmdY0;
                  x0_d    = cmdX0;
                  x1_d    = x1c;
                  y1_d    = y1c;
                  color_d = cmdColor;
                  done_d  = (cmdX0 == x1c) && (cmdY0 == y1c);
               end
            end
         end
         FILL: begin
            if (x_q < x1_q) begin
               x_d     = x_inc;
               write_d = 1'b1;
               busy_d  = 1'b1;
               done_d  = (x_inc == x1_q) && (y_q == y1_q);
            end else if (y_q < y1_q) begin
               x_d     = x0_q;
               y_d     = y_inc;
               write_d = 1'b1;
               busy_d  = 1'b1;
               done_d  = (x0_q == x1_q) && (y_inc == y1_q);
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         x0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
         write_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         color_q <= color_d;
         write_q <= write_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: expected pixels are queued when a
// command is issued and checked against every write the engine produces.
module tb_rect_fill_engine;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        cmdValid = 1'b0;
   logic        cmdReady;
   logic [6:0]  cmdX0 = '0, cmdY0 = '0, cmdX1 = '0, cmdY1 = '0;
   logic [2:0]  cmdColor = '0;
   logic        write;
   logic [13:0] writeAddress;
   logic [2:0]  writeData;
   logic        busy;
   logic        done;

   typedef struct packed {
      logic [13:0] addr;
      logic [2:0]  data;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          failed = 0;
   int          n_writes = 0;
   int          max_y = 0;
   logic [13:0] last_addr = '0;
   bit          mon_done_chk = 1'b1;

   rect_fill_engine #(.HEIGHT(96), .WIDTH(128)) dut (
      .clk(clk), .resetN(resetN), .cmdValid(cmdValid), .cmdReady(cmdReady),
      .cmdX0(cmdX0), .cmdY0(cmdY0), .cmdX1(cmdX1), .cmdY1(cmdY1),
      .cmdColor(cmdColor), .write(write), .writeAddress(writeAddress),
      .writeData(writeData), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Monitor: every write must match the head of the expected-pixel queue
   always @(negedge clk) begin
      exp_t e;
      if (resetN && write) begin
         n_writes++;
         last_addr = writeAddress;
         if (int'(writeAddress[13:7]) > max_y) max_y = int'(writeAddress[13:7]);
         tests++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_write addr=%h data=%0d", writeAddress, writeData);
         end else begin
            e = exp_q.pop_front();
            if (writeAddress !== e.addr || writeData !== e.data || done !== e.last || busy !== 1'b1)
            begin
               failed++;
               $display("FAIL pixel got addr=%h data=%0d done=%b busy=%b exp addr=%h data=%0d done=%b busy=1",
                        writeAddress, writeData, done, busy, e.addr, e.data, e.last);
            end
         end
      end else if (resetN && mon_done_chk) begin
         tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL idle_outputs got done=%b busy=%b exp done=0 busy=0", done, busy);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int push_model(input int x0, input int y0, input int x1, input int y1,
                                     input logic [2:0] c);
      int y1c = (y1 > 95) ? 95 : y1;
      int n = 0;
      exp_t e;
      if (x0 > x1 || y0 > y1c) return 0;
      for (int y = y0; y <= y1c; y++) begin
         for (int x = x0; x <= x1; x++) begin
            e.addr = {7'(y), 7'(x)};
            e.data = c;
            e.last = (x == x1) && (y == y1c);
            exp_q.push_back(e);
            n++;
         end
      end
      return n;
   endfunction

   // Issues one command; returns at #1 after the acceptance edge with inputs scrambled
   task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [2:0] c);
      int n = 0;
      void'(push_model(x0, y0, x1, y1, c));
      @(negedge clk);
      cmdX0 = 7'(x0); cmdY0 = 7'(y0); cmdX1 = 7'(x1); cmdY1 = 7'(y1); cmdColor = c;
      cmdValid = 1'b1;
      while (cmdReady !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         tests++; failed++;
         $display("FAIL cmd_ready_timeout got cmdReady=%b exp 1", cmdReady);
      end
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      cmdX0 = 7'($urandom); cmdY0 = 7'($urandom); cmdX1 = 7'($urandom);
      cmdY1 = 7'($urandom); cmdColor = 3'($urandom);
   endtask

   task automatic wait_drain(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         #1;
         if (exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      tests++;
      if (cmdReady !== 1'b0 || write !== 1'b0 || writeAddress !== 14'h0 || writeData !== 3'h0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         failed++;
         $display("FAIL reset_state got rdy=%b wr=%b addr=%h data=%0d busy=%b done=%b exp all 0",
                  cmdReady, write, writeAddress, writeData, busy, done);
      end
      resetN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         tests++;
         if (cmdReady !== 1'b1 || write !== 1'b0) begin
            failed++;
            $display("FAIL idle_after_reset cycle %0d got rdy=%b wr=%b exp rdy=1 wr=0", i, cmdReady, write);
         end
      end
   endtask

   task automatic test_rect;
      int base = n_writes;
      bit ok;
      send_cmd(2, 3, 4, 4, 3'd5);
      @(negedge clk);
      tests++;
      if (write !== 1'b1 || writeAddress !== 14'h182) begin
         failed++;
         $display("FAIL first_write_latency got wr=%b addr=%h exp wr=1 addr=182", write, writeAddress);
      end
      wait_drain(50, ok);
      tests++;
      if (!ok) begin failed++; $display("FAIL rect_drain got pending=%0d exp 0", exp_q.size()); end
      tests++;
      if (n_writes - base != 6) begin
         failed++; $display("FAIL rect_count got %0d exp 6", n_writes - base);
      end
      @(negedge clk);
      tests++;
      if (cmdReady !== 1'b1 || write !== 1'b0) begin
         failed++;
         $display("FAIL ready_after_done got rdy=%b wr=%b exp rdy=1 wr=0", cmdReady, write);
      end
   endtask

   task automatic test_clip;
      int base = n_writes;
      bit ok;
      max_y = 0;
      send_cmd(0, 90, 127, 127, 3'd7);
      wait_drain(1000, ok);
      tests++;
      if (!ok) begin failed++; $display("FAIL clip_drain got pending=%0d exp 0", exp_q.size()); end
      tests++;
      if (n_writes - base != 768) begin
         failed++; $display("FAIL clip_count got %0d exp 768", n_writes - base);
      end
      tests++;
      if (last_addr !== 14'h2FFF) begin
         failed++; $display("FAIL clip_last_addr got %h exp 2fff", last_addr);
      end
      tests++;
      if (max_y > 95) begin failed++; $display("FAIL clip_max_row got %0d exp <=95", max_y); end
   endtask

   task automatic test_empty;
      int cmds[3][4] = '{'{10, 0, 9, 5}, '{0, 100, 5, 120}, '{0, 50, 3, 40}};
      int base = n_writes;
      mon_done_chk = 1'b0;
      for (int k = 0; k < 3; k++) begin
         send_cmd(cmds[k][0], cmds[k][1], cmds[k][2], cmds[k][3], 3'd2);
         @(negedge clk);
         tests++;
         if (done !== 1'b1 || write !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL empty_done[%0d] got done=%b wr=%b busy=%b exp done=1 wr=0 busy=0",
                     k, done, write, busy);
         end
         @(negedge clk);
         tests++;
         if (done !== 1'b0 || write !== 1'b0) begin
            failed++;
            $display("FAIL empty_done_width[%0d] got done=%b wr=%b exp 0 0", k, done, write);
         end
      end
      mon_done_chk = 1'b1;
      tests++;
      if (n_writes != base) begin
         failed++; $display("FAIL empty_writes got %0d exp 0", n_writes - base);
      end
   endtask

   task automatic test_back_to_back;
      int base = n_writes;
      bit ok;
      void'(push_model(10, 20, 10, 20, 3'd3));
      void'(push_model(40, 60, 40, 60, 3'd6));
      @(negedge clk);
      tests++;
      if (cmdReady !== 1'b1) begin failed++; $display("FAIL b2b_ready got %b exp 1", cmdReady); end
      cmdX0 = 7'd10; cmdY0 = 7'd20; cmdX1 = 7'd10; cmdY1 = 7'd20; cmdColor = 3'd3;
      cmdValid = 1'b1;
      @(posedge clk);
      #1;
      cmdX0 = 7'd40; cmdY0 = 7'd60; cmdX1 = 7'd40; cmdY1 = 7'd60; cmdColor = 3'd6;
      @(negedge clk);
      tests++;
      if (cmdReady !== 1'b0 || write !== 1'b1 || done !== 1'b1) begin
         failed++;
         $display("FAIL b2b_first got rdy=%b wr=%b done=%b exp rdy=0 wr=1 done=1", cmdReady, write, done);
      end
      @(negedge clk);
      tests++;
      if (cmdReady !== 1'b1 || write !== 1'b0) begin
         failed++;
         $display("FAIL b2b_gap got rdy=%b wr=%b exp rdy=1 wr=0", cmdReady, write);
      end
      @(posedge clk);
      #1;
      cmdValid = 1'b0;
      cmdX0 = 7'd0; cmdY0 = 7'd0; cmdX1 = 7'd127; cmdY1 = 7'd127;
      wait_drain(20, ok);
      tests++;
      if (!ok || n_writes - base != 2) begin
         failed++;
         $display("FAIL b2b_count got %0d pending=%0d exp 2 pending=0", n_writes - base, exp_q.size());
      end
      // Inputs are scrambled right after acceptance inside send_cmd
      send_cmd(100, 5, 102, 6, 3'd1);
      wait_drain(30, ok);
      tests++;
      if (!ok) begin failed++; $display("FAIL midfill_change got pending=%0d exp 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_fill;
      int base;
      send_cmd(0, 0, 127, 127, 3'd4);
      base = n_writes;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #1;
         if (n_writes - base >= 100) break;
      end
      tests++;
      if (n_writes - base != 100) begin
         failed++; $display("FAIL midfill_progress got %0d exp 100", n_writes - base);
      end
      #2;
      resetN = 1'b0;
      #1;
      tests++;
      if (write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmdReady !== 1'b0) begin
         failed++;
         $display("FAIL async_reset got wr=%b busy=%b done=%b rdy=%b exp 0 0 0 0",
                  write, busy, done, cmdReady);
      end
      exp_q.delete();
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      base = n_writes;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         tests++;
         if (write !== 1'b0 || done !== 1'b0 || cmdReady !== 1'b1) begin
            failed++;
            $display("FAIL abandoned_cmd cycle %0d got wr=%b done=%b rdy=%b exp 0 0 1",
                     i, write, done, cmdReady);
         end
      end
      tests++;
      if (n_writes != base || writeAddress !== 14'h0) begin
         failed++;
         $display("FAIL post_reset got writes=%0d addr=%h exp 0 0000", n_writes - base, writeAddress);
      end
   endtask

   initial begin
      test_reset;
      test_rect;
      test_clip;
      test_empty;
      test_back_to_back;
      test_reset_mid_fill;
      tests++;
      if (exp_q.size() != 0) begin
         failed++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
